// File: rtl/sn_collector_pkg.sv
// Shared types and default constants for the sn/i counter result collector.
package sn_collector_pkg;

  localparam int SN_WIDTH_DEF = 8;
  localparam int SN_LIMIT_DEF = 70;
  localparam int SN_CYC_W_DEF = 16;

  typedef enum logic [1:0] {
    WAIT_INIT = 2'd0,
    RUN       = 2'd1,
    REPORT    = 2'd2,
    RESTART   = 2'd3
  } sn_collector_state_t;

endpackage

// File: rtl/sn_collector_sat.sv
// sat_counter: up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter
  import sn_collector_pkg::*;
#(
  parameter int W = SN_CYC_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins over enable; hold once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {W{1'b0}};
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sn_collector.sv
// Collects final sn and run length of the bounded counter, hands it over via valid/ready
// and pulses a counter restart. Optional consistency checker: SN_COLLECTOR_CHECK_EN.
module sn_collector
  import sn_collector_pkg::*;
#(
  parameter int WIDTH = SN_WIDTH_DEF,
  parameter int LIMIT = SN_LIMIT_DEF,
  parameter int CYC_W = SN_CYC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sn_i,
  input  logic [WIDTH-1:0] i_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [WIDTH-1:0] res_sn_o,
  output logic [CYC_W-1:0] res_cycles_o,
  output logic             cnt_rst_o,
  output logic             err_o
);

  localparam logic [WIDTH:0] LIMIT_W = (WIDTH + 1)'(LIMIT);

  sn_collector_state_t state_q, state_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_sn_q, res_sn_d;
  logic [CYC_W-1:0] res_cycles_q, res_cycles_d;
  logic             cnt_rst_q, cnt_rst_d;
  logic             cyc_clr_s;
  logic             cyc_en_s;
  logic [CYC_W-1:0] cyc_s;
  logic             init_s;
  logic             done_s;

  assign init_s = (sn_i == {WIDTH{1'b0}}) && (i_i == {{(WIDTH-1){1'b0}}, 1'b1});
  // Widened by one bit so the compare stays unsigned regardless of LIMIT.
  assign done_s = ({1'b0, i_i} > LIMIT_W);

  sat_counter #(
    .W (CYC_W)
  ) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cyc_clr_s),
    .en_i  (cyc_en_s),
    .cnt_o (cyc_s)
  );

  // Next-state, result capture, handshake and restart pulse.
  always_comb begin
    state_d      = state_q;
    res_valid_d  = res_valid_q;
    res_sn_d     = res_sn_q;
    res_cycles_d = res_cycles_q;
    cnt_rst_d    = 1'b0;
    cyc_clr_s    = 1'b0;
    cyc_en_s     = 1'b0;
    case (state_q)
      WAIT_INIT, RESTART: begin
        if (init_s) begin
          state_d   = RUN;
          cyc_clr_s = 1'b1;
        end else begin
          state_d   = state_q;
        end
      end
      RUN: begin
        if (done_s) begin
          res_sn_d     = sn_i;
          res_cycles_d = cyc_s;
          res_valid_d  = 1'b1;
          state_d      = REPORT;
        end else begin
          cyc_en_s     = 1'b1;
        end
      end
      REPORT: begin
        if (res_ready_i) begin
          res_valid_d = 1'b0;
          cnt_rst_d   = 1'b1;
          state_d     = RESTART;
        end else begin
          state_d     = REPORT;
        end
      end
      default: begin
        state_d     = WAIT_INIT;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_INIT;
      res_valid_q  <= 1'b0;
      res_sn_q     <= {WIDTH{1'b0}};
      res_cycles_q <= {CYC_W{1'b0}};
      cnt_rst_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      res_valid_q  <= res_valid_d;
      res_sn_q     <= res_sn_d;
      res_cycles_q <= res_cycles_d;
      cnt_rst_q    <= cnt_rst_d;
    end
  end

  assign res_valid_o  = res_valid_q;
  assign res_sn_o     = res_sn_q;
  assign res_cycles_o = res_cycles_q;
  assign cnt_rst_o    = cnt_rst_q;

`ifdef SN_COLLECTOR_CHECK_EN
  logic [WIDTH:0] sn_inc_s;
  logic           err_q, err_d;

  assign sn_inc_s = {1'b0, sn_i} + {{WIDTH{1'b0}}, 1'b1};

  // Sticky error: counter must step in lockstep and end exactly at LIMIT.
  always_comb begin
    err_d = err_q;
    if (state_q == RUN) begin
      if (sn_inc_s != {1'b0, i_i}) begin
        err_d = 1'b1;
      end else if (done_s && ({1'b0, sn_i} != LIMIT_W)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      err_d = err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sn_collector.sv
// Self-checking bench for sn_collector; expected results come from a run-length model
// computed from the stimulus schedule.
module tb_sn_collector;

  localparam int W  = 8;
  localparam int LIM = 70;
  localparam int CW = 16;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  sn_i;
  logic [W-1:0]  i_i;
  logic          res_valid_o;
  logic          res_ready_i;
  logic [W-1:0]  res_sn_o;
  logic [CW-1:0] res_cycles_o;
  logic          cnt_rst_o;
  logic          err_o;

  int checks;
  int failures;

  sn_collector #(.WIDTH(W), .LIMIT(LIM), .CYC_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sn_i         (sn_i),
    .i_i          (i_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_sn_o     (res_sn_o),
    .res_cycles_o (res_cycles_o),
    .cnt_rst_o    (cnt_rst_o),
    .err_o        (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Any (sn,i) pair except the run-start pattern.
  task automatic drive_garbage();
    sn_i = W'($urandom);
    i_i  = W'($urandom);
    if (sn_i == 0 && i_i == 1) i_i = 8'd71;
  endtask

  // One complete run: start, count (optional stall), report with ready delay, restart idle.
  task automatic run_once(input int stall_at, input int stall_len, input int rdy_dly,
                          input int idle_len, input string tag);
    int n_between;
    int exp_cyc;
    int reps;
    logic early;
    n_between = 0;
    early = 1'b0;
    res_ready_i = 1'($urandom);
    sn_i = 8'd0;
    i_i  = 8'd1;
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || cnt_rst_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_start got valid=%0b cnt_rst=%0b exp 0 0", tag, res_valid_o, cnt_rst_o);
    end
    for (int k = 2; k <= LIM + 1; k++) begin
      reps = (k == stall_at) ? stall_len + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        sn_i = W'(k - 1);
        i_i  = W'(k);
        if (res_valid_o !== 1'b0) early = 1'b1;
        tick();
        if (k <= LIM) n_between++;
        res_ready_i = 1'($urandom);
      end
    end
    exp_cyc = (n_between > 65535) ? 65535 : n_between;
    res_ready_i = (rdy_dly == 0);
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid got=1 exp=0", tag);
    end
    checks++;
    if (res_valid_o !== 1'b1 || res_sn_o !== W'(LIM) || res_cycles_o !== CW'(exp_cyc)) begin
      failures++;
      $display("FAIL %s_capture got v=%0b sn=%0d cyc=%0d exp v=1 sn=%0d cyc=%0d",
               tag, res_valid_o, res_sn_o, res_cycles_o, LIM, exp_cyc);
    end
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_err got=%0b exp=0", tag, err_o);
    end
    for (int d = 0; d < rdy_dly; d++) begin
      drive_garbage();
      res_ready_i = 1'b0;
      tick();
      checks++;
      if (res_valid_o !== 1'b1 || res_sn_o !== W'(LIM) || res_cycles_o !== CW'(exp_cyc)
          || cnt_rst_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold%0d got v=%0b sn=%0d cyc=%0d rst=%0b exp v=1 sn=%0d cyc=%0d rst=0",
                 tag, d, res_valid_o, res_sn_o, res_cycles_o, cnt_rst_o, LIM, exp_cyc);
      end
    end
    res_ready_i = 1'b1;
    drive_garbage();
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || cnt_rst_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_transfer got v=%0b cnt_rst=%0b exp v=0 cnt_rst=1", tag, res_valid_o, cnt_rst_o);
    end
    for (int d = 0; d < idle_len; d++) begin
      sn_i = 8'd70;
      i_i  = 8'd71;
      if (d % 2 == 1) drive_garbage();
      res_ready_i = 1'($urandom);
      tick();
      checks++;
      if (res_valid_o !== 1'b0 || cnt_rst_o !== 1'b0) begin
        failures++;
        $display("FAIL %s_restart%0d got v=%0b cnt_rst=%0b exp 0 0", tag, d, res_valid_o, cnt_rst_o);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (res_valid_o !== 1'b0 || res_sn_o !== 8'd0 || res_cycles_o !== 16'd0
        || cnt_rst_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL %s got v=%0b sn=%0d cyc=%0d rst=%0b err=%0b exp all 0",
               tag, res_valid_o, res_sn_o, res_cycles_o, cnt_rst_o, err_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    res_ready_i = 1'b0;
    sn_i = 8'd0;
    i_i  = 8'd0;
    #3;
    check_all_zero("reset_async");
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      sn_i = 8'd70;
      i_i  = 8'd71;
      res_ready_i = 1'b1;
      tick();
    end
    check_all_zero("reset_wait_init");
  endtask

  task automatic test_nominal();
    run_once(0, 0, 0, 0, "nominal");
  endtask

  task automatic test_backpressure();
    run_once(0, 0, 5, 1, "backpressure");
  endtask

  task automatic test_stall();
    run_once(10, 20, 0, 1, "stall");
  endtask

  task automatic test_restart();
    run_once(0, 0, 1, 3, "restart_a");
    run_once(0, 0, 0, 2, "restart_b");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      run_once(int'($urandom_range(2, 71)), int'($urandom_range(0, 30)),
               int'($urandom_range(0, 6)), int'($urandom_range(0, 4)), "random");
    end
  endtask

  task automatic test_async_reset();
    sn_i = 8'd0;
    i_i  = 8'd1;
    tick();
    for (int k = 2; k < 30; k++) begin
      sn_i = W'(k - 1);
      i_i  = W'(k);
      tick();
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_mid_run");
    tick();
    rst_n = 1'b1;
    for (int k = 30; k < 40; k++) begin
      sn_i = 8'd70;
      i_i  = 8'd71;
      tick();
    end
    check_all_zero("reset_no_spurious");
    sn_i = 8'd0;
    i_i  = 8'd1;
    tick();
    for (int k = 2; k <= LIM + 1; k++) begin
      sn_i = W'(k - 1);
      i_i  = W'(k);
      res_ready_i = 1'b0;
      tick();
    end
    checks++;
    if (res_valid_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_valid got=%0b exp=1", res_valid_o);
    end
    #2 rst_n = 1'b0;
    #1 check_all_zero("reset_in_report");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      res_ready_i = 1'b1;
      tick();
    end
    check_all_zero("reset_result_dropped");
    run_once(0, 0, 2, 1, "after_reset");
  endtask

`ifdef SN_COLLECTOR_CHECK_EN
  task automatic test_checker();
    sn_i = 8'd0;
    i_i  = 8'd1;
    tick();
    sn_i = 8'd1;
    i_i  = 8'd2;
    tick();
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL checker_clean got=%0b exp=0", err_o);
    end
    sn_i = 8'd5;
    i_i  = 8'd9;
    tick();
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL checker_rise got=%0b exp=1", err_o);
    end
    for (int k = 10; k < 16; k++) begin
      sn_i = W'(k - 1);
      i_i  = W'(k);
      tick();
    end
    checks++;
    if (err_o !== 1'b1) begin
      failures++;
      $display("FAIL checker_sticky got=%0b exp=1", err_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (err_o !== 1'b0) begin
      failures++;
      $display("FAIL checker_reset got=%0b exp=0", err_o);
    end
    tick();
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_stall();
    test_restart();
    test_random();
    test_async_reset();
`ifdef SN_COLLECTOR_CHECK_EN
    test_checker();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
